// File: rtl/rr_sel_arbiter4_if.sv
// rr_sel_arbiter4_if: request/grant bundle between requesters and the mux-select arbiter
interface rr_sel_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;
    modport master (output req, done, input gnt, sel, gnt_valid);
    modport slave  (input req, done, output gnt, sel, gnt_valid);
endinterface

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4: 4-channel round-robin arbiter producing a registered, glitch-free mux select
module rr_sel_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input logic               clk,
    input logic               rst,
    rr_sel_arbiter4_if.slave  bus
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state, w_state;
    logic [3:0]        r_gnt, w_gnt;
    logic [1:0]        r_sel, w_sel;
    logic [1:0]        r_ptr, w_ptr;
    logic [HOLD_W-1:0] r_hold, w_hold;
    logic [1:0]        w_win;
    logic              w_rel;

    // First requester after p, wrapping round so p itself is scanned last.
    function automatic logic [1:0] win(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        win = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) win = idx;
        end
    endfunction

    // State register: arbitration state, registered grant/select, pointer, hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= 2'd3;
            r_hold  <= '0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_sel   <= w_sel;
            r_ptr   <= w_ptr;
            r_hold  <= w_hold;
        end
    end

    // Next state: grant on any request, hold until release, re-arbitrate without a bubble.
    always_comb begin
        w_win   = win(r_ptr, bus.req);
        w_rel   = bus.done || !bus.req[r_sel] || (MAX_HOLD != 0 && r_hold == HOLD_LAST);
        w_state = r_state;
        w_gnt   = r_gnt;
        w_sel   = r_sel;
        w_ptr   = r_ptr;
        w_hold  = r_hold;
        if (r_state == S_GRANT && !w_rel) begin
            w_hold = (r_hold == '1) ? r_hold : r_hold + 1'b1;
        end else if (|bus.req) begin
            w_state = S_GRANT;
            w_gnt   = 4'b0001 << w_win;
            w_sel   = w_win;
            w_ptr   = w_win;
            w_hold  = '0;
        end else begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_hold  = '0;
        end
    end

    // Outputs come straight from registers so the mux select never glitches.
    always_comb begin
        bus.gnt       = r_gnt;
        bus.sel       = r_sel;
        bus.gnt_valid = |r_gnt;
    end
endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// tb_rr_sel_arbiter4: directed self-checking bench for the round-robin mux-select arbiter
module tb_rr_sel_arbiter4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    rr_sel_arbiter4_if bus ();
    rr_sel_arbiter4_if bus4 ();

    rr_sel_arbiter4 u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    rr_sel_arbiter4 #(.MAX_HOLD(4), .HOLD_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] g, input logic [1:0] s, input logic v);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, ".sel"}, 32'(bus.sel), 32'(s));
        check({tag, ".gv"}, 32'(bus.gnt_valid), 32'(v));
    endtask

    initial begin
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus.req = '0; bus.done = 1'b0;
        bus4.req = '0; bus4.done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_gnt("reset", 4'b0000, 2'd0, 1'b0);
        check("reset4.gnt", 32'(bus4.gnt), 32'h0);

        // done while idle is ignored
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        expect_gnt("idle_done", 4'b0000, 2'd0, 1'b0);
        tick();
        expect_gnt("idle_done2", 4'b0000, 2'd0, 1'b0);

        // MAX_HOLD=4: sole requester re-granted after 4 cycles, then ch1 wins next release
        bus4.req = 4'b0001;
        tick();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to4_a%0d", c), 32'(bus4.gnt), 32'h1);
            tick();
        end
        bus4.req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to4_b%0d", c), 32'(bus4.gnt), 32'h1);
            tick();
        end
        check("to4_sw.gnt", 32'(bus4.gnt), 32'h2);
        check("to4_sw.sel", 32'(bus4.sel), 32'h1);
        bus4.req = '0;

        // all request, done every 3rd cycle: 0,1,2,3,0 back to back
        bus.req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                expect_gnt($sformatf("rr_g%0d_c%0d", g, c), 4'b0001 << seq[g], seq[g], 1'b1);
                bus.done = (c == 2);
                tick();
                bus.done = 1'b0;
            end
        end
        bus.req = '0;
        tick();
        expect_gnt("rr_idle", 4'b0000, 2'd1, 1'b0);

        // single request, then drop
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b0100;
        tick();
        expect_gnt("ch2_gnt", 4'b0100, 2'd2, 1'b1);
        tick();
        expect_gnt("ch2_hold", 4'b0100, 2'd2, 1'b1);
        bus.req = '0;
        tick();
        expect_gnt("ch2_drop", 4'b0000, 2'd2, 1'b0);

        // pointer after ch3: ch0 first, then ch3
        bus.req = 4'b1000;
        tick();
        expect_gnt("ch3_gnt", 4'b1000, 2'd3, 1'b1);
        bus.req = '0;
        tick();
        expect_gnt("ch3_rel", 4'b0000, 2'd3, 1'b0);
        bus.req = 4'b1001;
        tick();
        expect_gnt("ptr_ch0", 4'b0001, 2'd0, 1'b1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        expect_gnt("ptr_ch3", 4'b1000, 2'd3, 1'b1);

        // reset mid-grant
        bus.req = 4'b1111;
        rst = 1'b1;
        tick();
        expect_gnt("rst_mid", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_gnt("rst_after", 4'b0001, 2'd0, 1'b1);

        // default MAX_HOLD=16 timeout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b0011;
        tick();
        for (int c = 0; c < 16; c++) begin
            check($sformatf("to16_%0d", c), 32'(bus.gnt), 32'h1);
            tick();
        end
        expect_gnt("to16_sw", 4'b0010, 2'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
